// File: rtl/instruction_fetch_unit_if.sv
// Bundle between the fetch unit, the RAM port, and the execute stage.
// master = fetch unit side, slave = RAM/execute side.
interface instruction_fetch_unit_if;
  logic [15:0] bus_RAM_ADDRESS;
  logic        wire_RW;
  logic [15:0] bus_RAM_DATA_IN;
  logic [15:0] bus_RAM_DATA_OUT;

  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_word;
  logic [15:0] instr_operand;
  logic [15:0] instr_pc;

  logic        exec_mem_req;
  logic        exec_mem_we;
  logic [15:0] exec_mem_addr;
  logic [15:0] exec_mem_wdata;
  logic [15:0] exec_mem_rdata;
  logic        exec_mem_done;

  logic        redirect_valid;
  logic [15:0] redirect_pc;

  modport master (
    output bus_RAM_ADDRESS,
    output wire_RW,
    output bus_RAM_DATA_IN,
    input  bus_RAM_DATA_OUT,
    output instr_valid,
    input  instr_ready,
    output instr_word,
    output instr_operand,
    output instr_pc,
    input  exec_mem_req,
    input  exec_mem_we,
    input  exec_mem_addr,
    input  exec_mem_wdata,
    output exec_mem_rdata,
    output exec_mem_done,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  bus_RAM_ADDRESS,
    input  wire_RW,
    input  bus_RAM_DATA_IN,
    output bus_RAM_DATA_OUT,
    input  instr_valid,
    output instr_ready,
    input  instr_word,
    input  instr_operand,
    input  instr_pc,
    output exec_mem_req,
    output exec_mem_we,
    output exec_mem_addr,
    output exec_mem_wdata,
    input  exec_mem_rdata,
    input  exec_mem_done,
    output redirect_valid,
    output redirect_pc
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Front end of cpu_v: owns the single RAM port, fetches one/two-word instructions,
// arbitrates execute-stage data accesses onto the same port and applies PC redirects.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                            wire_clock,
  input  logic                            wire_reset,
  instruction_fetch_unit_if.master        bus,
  output logic [15:0]                     data_debug
);

  typedef enum logic [3:0] {
    StArb   = 4'd0,
    StFAddr = 4'd1,
    StFData = 4'd2,
    StXAddr = 4'd3,
    StXData = 4'd4,
    StHold  = 4'd5,
    StMAddr = 4'd6,
    StMData = 4'd7,
    StMDone = 4'd8
  } state_e;

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [15:0] word_q, word_d;
  logic [15:0] operand_q, operand_d;
  logic [15:0] ipc_q, ipc_d;
  logic [15:0] rdata_q, rdata_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic        two_word;
  logic [15:0] pc_inc;

  // LOAD (110000) and STORE (110001) carry an address operand word.
  assign two_word = (bus.bus_RAM_DATA_OUT[15:11] == 5'b11000);
  assign pc_inc   = pc_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rw_d      = 1'b0;
    word_d    = word_q;
    operand_d = operand_q;
    ipc_d     = ipc_q;
    rdata_d   = rdata_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;

    unique case (state_q)
      StArb: begin
        if (bus.redirect_valid) begin
          pc_d = bus.redirect_pc;
        end else if (bus.exec_mem_req) begin
          state_d = StMAddr;
          ret_d   = StArb;
          addr_d  = bus.exec_mem_addr;
          rw_d    = bus.exec_mem_we;
          if (bus.exec_mem_we) wdata_d = bus.exec_mem_wdata;
        end else begin
          state_d = StFAddr;
          addr_d  = pc_q;
        end
      end

      StFAddr: begin
        if (bus.redirect_valid) begin
          state_d = StArb;
          pc_d    = bus.redirect_pc;
        end else begin
          state_d = StFData;
        end
      end

      StFData: begin
        if (bus.redirect_valid) begin
          state_d = StArb;
          pc_d    = bus.redirect_pc;
        end else begin
          word_d = bus.bus_RAM_DATA_OUT;
          ipc_d  = pc_q;
          pc_d   = pc_inc;
          if (two_word) begin
            state_d = StXAddr;
            addr_d  = pc_inc;
          end else begin
            state_d   = StHold;
            operand_d = 16'h0000;
          end
        end
      end

      StXAddr: begin
        if (bus.redirect_valid) begin
          state_d = StArb;
          pc_d    = bus.redirect_pc;
        end else begin
          state_d = StXData;
        end
      end

      StXData: begin
        if (bus.redirect_valid) begin
          state_d = StArb;
          pc_d    = bus.redirect_pc;
        end else begin
          state_d   = StHold;
          operand_d = bus.bus_RAM_DATA_OUT;
          pc_d      = pc_inc;
        end
      end

      StHold: begin
        // A handshake wins; a coincident redirect then steers the next fetch.
        if (bus.instr_ready) begin
          state_d = StArb;
          if (bus.redirect_valid) pc_d = bus.redirect_pc;
        end else if (bus.redirect_valid) begin
          state_d = StArb;
          pc_d    = bus.redirect_pc;
        end else if (bus.exec_mem_req) begin
          state_d = StMAddr;
          ret_d   = StHold;
          addr_d  = bus.exec_mem_addr;
          rw_d    = bus.exec_mem_we;
          if (bus.exec_mem_we) wdata_d = bus.exec_mem_wdata;
        end
      end

      StMAddr: begin
        if (bus.redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = bus.redirect_pc;
        end
        state_d = rw_q ? StMDone : StMData;
      end

      StMData: begin
        if (bus.redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = bus.redirect_pc;
        end
        rdata_d = bus.bus_RAM_DATA_OUT;
        state_d = StMDone;
      end

      StMDone: begin
        // A redirect in this very cycle is the newest one and replaces any pending.
        pend_d = 1'b0;
        if (bus.redirect_valid) begin
          state_d = StArb;
          pc_d    = bus.redirect_pc;
        end else if (pend_q) begin
          state_d = StArb;
          pc_d    = pend_pc_q;
        end else begin
          state_d = ret_q;
        end
      end

      default: begin
        state_d = StArb;
      end
    endcase
  end

  always_ff @(posedge wire_clock or posedge wire_reset) begin
    if (wire_reset) begin
      state_q   <= StArb;
      ret_q     <= StArb;
      pc_q      <= RESET_PC;
      addr_q    <= 16'h0000;
      wdata_q   <= 16'h0000;
      rw_q      <= 1'b0;
      word_q    <= 16'h0000;
      operand_q <= 16'h0000;
      ipc_q     <= 16'h0000;
      rdata_q   <= 16'h0000;
      pend_q    <= 1'b0;
      pend_pc_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      word_q    <= word_d;
      operand_q <= operand_d;
      ipc_q     <= ipc_d;
      rdata_q   <= rdata_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  assign bus.bus_RAM_ADDRESS = addr_q;
  assign bus.wire_RW         = rw_q;
  assign bus.bus_RAM_DATA_IN = wdata_q;
  assign bus.instr_valid     = (state_q == StHold);
  assign bus.instr_word      = word_q;
  assign bus.instr_operand   = operand_q;
  assign bus.instr_pc        = ipc_q;
  assign bus.exec_mem_rdata  = rdata_q;
  assign bus.exec_mem_done   = (state_q == StMDone);
  assign data_debug          = {12'h000, state_q};

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end stage of `cpu_v` that owns the single RAM port. It fetches instruction words from RAM at PC and, for two-word instructions, fetches the address operand word too. It hands each complete instruction to the execute stage over a valid/ready handshake. It also muxes the execute stage's data-memory reads and writes (LOAD/STORE) onto the same RAM bus, and handles PC redirects (jumps) from execute.

## Interface
- `RESET_PC`, default 16'h0000, PC value loaded on reset.
- `wire_clock`  in  1  system clock; all state changes on the rising edge.
- `wire_reset`  in  1  asynchronous, active-high reset.
- `bus_RAM_ADDRESS`  out  16  RAM address, registered.
- `wire_RW`  out  1  RAM write enable (1 = write), registered.
- `bus_RAM_DATA_IN`  out  16  RAM write data, registered.
- `bus_RAM_DATA_OUT`  in  16  RAM read data. Valid in the cycle after the address is presented.
- `instr_valid`  out  1  an instruction is held for execute.
- `instr_ready`  in  1  execute accepts the instruction.
- `instr_word`  out  16  opcode word.
- `instr_operand`  out  16  second word for two-word opcodes; 16'h0000 otherwise.
- `instr_pc`  out  16  address of `instr_word`.
- `exec_mem_req`  in  1  execute requests a data access. Held high until `exec_mem_done`.
- `exec_mem_we`  in  1  1 = write, 0 = read.
- `exec_mem_addr`  in  16  data address.
- `exec_mem_wdata`  in  16  write data.
- `exec_mem_rdata`  out  16  read data, valid while `exec_mem_done` = 1.
- `exec_mem_done`  out  1  one-cycle completion pulse.
- `redirect_valid`  in  1  one-cycle jump request.
- `redirect_pc`  in  16  jump target.
- `data_debug`  out  16  {12'h000, state code}.

## Operation
- Two-word opcodes are `instr_word[15:10]` = 6'b110000 (LOAD) and 6'b110001 (STORE). All other opcodes are one word.
- PC arithmetic is modulo 2^16: 16'hFFFF + 1 = 16'h0000. An operand of an opcode at 16'hFFFF is read from 16'h0000.

States:
- **ARB**: decision cycle.
  - `redirect_valid` → PC ← `redirect_pc`, stay in ARB.
  - else `exec_mem_req` → M_ADDR, return target ARB.
  - else → F_ADDR.
- **F_ADDR**: `bus_RAM_ADDRESS` = PC, `wire_RW` = 0 → F_DATA.
- **F_DATA**: capture `bus_RAM_DATA_OUT` into `instr_word` and PC into `instr_pc`; PC ← PC+1.
  - Two-word opcode → X_ADDR.
  - else `instr_operand` ← 0 → HOLD.
- **X_ADDR / X_DATA**: same as F_ADDR/F_DATA but capture into `instr_operand`, PC ← PC+1 → HOLD.
- **HOLD**: `instr_valid` = 1.
  - `instr_valid` && `instr_ready` → ARB.
  - else `exec_mem_req` → M_ADDR, return target HOLD (`instr_valid` deasserted during the access, restored after).
- **M_ADDR**: drive `exec_mem_addr`; `wire_RW` = `exec_mem_we`; on write, `bus_RAM_DATA_IN` = `exec_mem_wdata`.
  - Write → M_DONE.
  - Read → M_DATA.
- **M_DATA**: capture `bus_RAM_DATA_OUT` into `exec_mem_rdata` → M_DONE.
- **M_DONE**: `exec_mem_done` = 1, `wire_RW` = 0. `exec_mem_req` is ignored this cycle → return target.

Exec requests arriving in F_*/X_* wait until the fetch reaches HOLD.

Redirect:
- In ARB, F_*, X_* or HOLD: discard any partial or held instruction, PC ← `redirect_pc`, → ARB. `instr_valid` is 0 from the next cycle.
- In M_*: latch it pending and apply at the M_DONE exit, overriding the return target.
- Coincident with a HOLD handshake: the instruction is accepted, then the redirect applies.
- A second redirect while one is pending replaces it.

## Timing
- Reset (async, immediate):
  - state = ARB, PC = `RESET_PC`.
  - `bus_RAM_ADDRESS`, `bus_RAM_DATA_IN`, `instr_word`, `instr_operand`, `instr_pc`, `exec_mem_rdata`, `data_debug` = 16'h0000.
  - `wire_RW`, `instr_valid`, `exec_mem_done` = 0.
- Reset mid-access aborts it. `wire_RW` drops asynchronously.
- First cycle after reset release is ARB. `bus_RAM_ADDRESS` = `RESET_PC` in cycle 2.
- Latency to `instr_valid`: one-word instruction in cycle 4; two-word in cycle 6.
- Back-to-back with `instr_ready` = 1: one instruction per 4 cycles (one-word) or per 6 cycles (two-word).
- Data access: read, `exec_mem_done` 3 cycles after entering M_ADDR; write, 2 cycles.
- `wire_RW` is never 1 outside M_ADDR.

## Test plan
- **Reset fetch:** reset, RAM[0]=16'h0401, `instr_ready`=1 → `bus_RAM_ADDRESS`=0 in cycle 2; `instr_valid`, `instr_word`=16'h0401, `instr_operand`=0, `instr_pc`=0 in cycle 4; next fetch address 1.
- **Two-word fetch:** RAM[0]=16'hC000 (LOAD), RAM[1]=16'h0050 → `instr_valid` in cycle 6 with `instr_word`=16'hC000, `instr_operand`=16'h0050; next fetch at 2.
- **Backpressure:** `instr_ready`=0 for 10 cycles → `instr_valid` and all `instr_*` stable, no RAM activity; accept → ARB then fetch of next PC.
- **Data access from HOLD:** in HOLD raise `exec_mem_req`, write 16'hBEEF to 16'h0050, then read it back → `wire_RW`=1 for exactly one cycle; read `exec_mem_rdata`=16'hBEEF with `exec_mem_done` pulse; `instr_valid` restored with an unchanged word.
- **Redirect:** `redirect_valid` with `redirect_pc`=16'h0100 during X_DATA → partial instruction dropped, `instr_valid` stays 0, next `bus_RAM_ADDRESS`=16'h0100. Redirect during M_DATA → read completes, then fetch from the target.
- **Wrap:** PC=16'hFFFF holding 16'hC400 (STORE) → operand read from 16'h0000, next PC=16'h0001.
